// File: rtl/jesd204_scrambler_pkg.sv
// Shared constants and the bit-serial LFSR step for the JESD204B 1 + x^14 + x^15 scrambler.
// lfsr_step is unrolled at elaboration into one XOR tree per output bit.
package jesd204_scrambler_pkg;

  localparam int LFSR_W       = 15;
  localparam int POLY_TAPS [2] = '{14, 15};
  localparam int MAX_BITS     = 64;

  typedef struct packed {
    logic [LFSR_W-1:0]   state;
    logic [MAX_BITS-1:0] bits;
  } lfsr_res_t;

  // data[n] is stream bit n; state[0] holds the newest history bit, state[14] the oldest.
  function automatic lfsr_res_t lfsr_step(input logic [LFSR_W-1:0]   state,
                                          input logic [MAX_BITS-1:0] data,
                                          input logic                descramble,
                                          input int                  nbits);
    lfsr_res_t         res;
    logic [LFSR_W-1:0] st;
    logic              fb;
    st       = state;
    fb       = 1'b0;
    res.bits = '0;
    for (int n = 0; n < MAX_BITS; n++) begin
      if (n < nbits) begin
        fb          = st[POLY_TAPS[0]-1] ^ st[POLY_TAPS[1]-1];
        res.bits[n] = data[n] ^ fb;
        st          = {st[LFSR_W-2:0], descramble ? data[n] : res.bits[n]};
      end
    end
    res.state = st;
    return res;
  endfunction

endpackage

// File: rtl/jesd204_scrambler_lane.sv
// One scrambler lane: octet/bit reordering into wire order plus the lane's own 15-bit LFSR.
// The output is combinational; the top level registers it.
module jesd204_scrambler_lane
  import jesd204_scrambler_pkg::*;
#(
  parameter int                BYTES = 4,
  parameter logic [LFSR_W-1:0] SEED  = 15'h7fff
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               accept_i,
  input  logic               reseed_i,
  input  logic               enable_i,
  input  logic               descramble_i,
  input  logic [BYTES*8-1:0] data_i,
  output logic [BYTES*8-1:0] data_o
);

  localparam int NB = BYTES * 8;

  logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_start;
  logic [MAX_BITS-1:0] stream;
  lfsr_res_t           res;

  // Wire order: octet 0 first, MSB first within each octet.
  always_comb begin
    stream = '0;
    for (int n = 0; n < NB; n++) begin
      stream[n] = data_i[(n / 8) * 8 + 7 - (n % 8)];
    end
  end

  assign lfsr_start = reseed_i ? SEED : lfsr_q;
  assign res        = lfsr_step(lfsr_start, stream, descramble_i, NB);

  always_comb begin
    data_o = data_i;
    if (enable_i) begin
      for (int n = 0; n < NB; n++) begin
        data_o[(n / 8) * 8 + 7 - (n % 8)] = res.bits[n];
      end
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept_i) begin
      lfsr_d = res.state;
    end else if (reseed_i) begin
      lfsr_d = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  if (NB < MAX_BITS) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^res.bits[MAX_BITS-1:NB];
  end

endmodule

// File: rtl/jesd204_lane_scrambler.sv
// Multi-lane JESD204B scrambler/descrambler with valid/ready flow control, runtime mode and reseed.
// One registered output stage; lanes are independent.
module jesd204_lane_scrambler
  import jesd204_scrambler_pkg::*;
#(
  parameter int                LANES              = 4,
  parameter int                BYTES              = 4,
  parameter logic [LFSR_W-1:0] SEED               = 15'h7fff,
  parameter logic              DEFAULT_DESCRAMBLE = 1'b0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_enable,
  input  logic                     cfg_descramble,
  input  logic                     cfg_load,
  input  logic                     reseed,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*BYTES*8-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*BYTES*8-1:0] out_data,
  output logic                     mode
);

  localparam int NB = BYTES * 8;
  localparam int W  = LANES * NB;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         mode_q, mode_d;
  logic [W-1:0] lane_out;
  logic         accept;

  assign in_ready = out_ready || !out_valid_q;
  assign accept   = in_valid && in_ready && resetn;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    jesd204_scrambler_lane #(
      .BYTES (BYTES),
      .SEED  (SEED)
    ) u_lane (
      .clk          (clk),
      .resetn       (resetn),
      .accept_i     (accept),
      .reseed_i     (reseed),
      .enable_i     (cfg_enable),
      .descramble_i (mode_q),
      .data_i       (in_data[l*NB +: NB]),
      .data_o       (lane_out[l*NB +: NB])
    );
  end

  // A beat accepted together with cfg_load still sees the old mode_q.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mode_d      = mode_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_out;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (cfg_load) begin
      mode_d = cfg_descramble;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mode_q      <= DEFAULT_DESCRAMBLE;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mode_q      <= mode_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_jesd204_lane_scrambler.sv
// Bench for jesd204_lane_scrambler: scrambler->descrambler loopback (4 lanes x 2 octets)
// and a single 4-octet lane instance, all checked against a bit-serial history model.
module tb_jesd204_lane_scrambler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, rstn_c;
  logic        a_en, a_desc, a_load, a_reseed, a_in_valid, a_in_ready, a_out_valid, a_mode;
  logic [63:0] a_in_data, a_out_data;
  logic        b_en, b_desc, b_load, b_reseed, b_in_ready, b_out_valid, b_out_ready, b_mode;
  logic [63:0] b_out_data;
  logic        c_en, c_desc, c_load, c_reseed, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_mode;
  logic [31:0] c_in_data, c_out_data;

  int errors = 0;
  int checks = 0;

  // hist[h] holds the last 15 bits of the stream feeding lane h, oldest first.
  // h = 0..3 scrambler A, 4..7 descrambler B, 8 single-lane C.
  bit hist [9][$];

  jesd204_lane_scrambler #(.LANES(4), .BYTES(2), .SEED(15'h7fff), .DEFAULT_DESCRAMBLE(1'b0)) u_a (
    .clk(clk), .resetn(rstn), .cfg_enable(a_en), .cfg_descramble(a_desc), .cfg_load(a_load),
    .reseed(a_reseed), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(b_in_ready), .out_data(a_out_data), .mode(a_mode));

  jesd204_lane_scrambler #(.LANES(4), .BYTES(2), .SEED(15'h7fff), .DEFAULT_DESCRAMBLE(1'b1)) u_b (
    .clk(clk), .resetn(rstn), .cfg_enable(b_en), .cfg_descramble(b_desc), .cfg_load(b_load),
    .reseed(b_reseed), .in_valid(a_out_valid), .in_ready(b_in_ready), .in_data(a_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .mode(b_mode));

  jesd204_lane_scrambler #(.LANES(1), .BYTES(4), .SEED(15'h7fff), .DEFAULT_DESCRAMBLE(1'b0)) u_c (
    .clk(clk), .resetn(rstn_c), .cfg_enable(c_en), .cfg_descramble(c_desc), .cfg_load(c_load),
    .reseed(c_reseed), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .mode(c_mode));

  task automatic seed_lane(input int h);
    hist[h].delete();
    repeat (15) hist[h].push_back(1'b1);
  endtask

  // Serialise octet 0 first, MSB first; x[n] ^ x[n-14] ^ x[n-15] with the right history stream.
  task automatic ref_lane(input int h, input logic [63:0] word, input int nbytes,
                          input bit desc, input bit en, output logic [63:0] res);
    bit d, s;
    res = '0;
    for (int k = 0; k < nbytes; k++) begin
      for (int b = 7; b >= 0; b--) begin
        d = word[k*8+b];
        s = d ^ hist[h][0] ^ hist[h][1];
        res[k*8+b] = en ? s : d;
        hist[h].push_back(desc ? d : s);
        void'(hist[h].pop_front());
      end
    end
  endtask

  task automatic model_a(input logic [63:0] din, input bit en, input bit rs, output logic [63:0] dout);
    logic [63:0] w, r;
    dout = '0;
    for (int l = 0; l < 4; l++) begin
      if (rs) seed_lane(l);
      w = '0;
      w[15:0] = din[l*16 +: 16];
      ref_lane(l, w, 2, 1'b0, en, r);
      dout[l*16 +: 16] = r[15:0];
    end
  endtask

  task automatic model_b(input logic [63:0] din, output logic [63:0] dout);
    logic [63:0] w, r;
    dout = '0;
    for (int l = 0; l < 4; l++) begin
      w = '0;
      w[15:0] = din[l*16 +: 16];
      ref_lane(4 + l, w, 2, 1'b1, 1'b1, r);
      dout[l*16 +: 16] = r[15:0];
    end
  endtask

  task automatic do_reset_ab();
    @(negedge clk);
    rstn = 1'b0; a_in_valid = 1'b0; a_reseed = 1'b0; a_en = 1'b1; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int h = 0; h < 8; h++) seed_lane(h);
  endtask

  task automatic do_reset_c();
    @(negedge clk);
    rstn_c = 1'b0; c_in_valid = 1'b0; c_reseed = 1'b0; c_load = 1'b0; c_en = 1'b1; c_out_ready = 1'b1;
    @(negedge clk);
    rstn_c = 1'b1;
    seed_lane(8);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0; rstn_c = 1'b0;
    a_in_valid = 1'b1; a_in_data = {$urandom, $urandom}; b_out_ready = 1'b1;
    c_in_valid = 1'b1; c_in_data = $urandom; c_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_data !== 64'h0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", a_out_data); end
    checks++; if (a_mode !== 1'b0) begin errors++; $display("FAIL reset_a_mode: got %b expected 0", a_mode); end
    checks++; if (b_mode !== 1'b1) begin errors++; $display("FAIL reset_b_mode: got %b expected 1", b_mode); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", b_out_valid); end
    checks++; if (c_out_valid !== 1'b0 || c_out_data !== 32'h0) begin errors++; $display("FAIL reset_c: got %b/%h expected 0/0", c_out_valid, c_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b expected 1", a_in_ready); end
    rstn = 1'b1; rstn_c = 1'b1; a_in_valid = 1'b0; c_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_vector();
    logic [63:0] r;
    do_reset_c();
    c_in_valid = 1'b1; c_in_data = 32'h0;
    ref_lane(8, 64'h0, 4, 1'b0, 1'b1, r);
    @(negedge clk);
    c_in_valid = 1'b0;
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL vector_latency: got valid=%b expected 1", c_out_valid); end
    checks++; if (c_out_data !== 32'h0C000200) begin errors++; $display("FAIL vector_zero: got %h expected 0c000200", c_out_data); end
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL vector_drain: got valid=%b expected 0", c_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    logic [31:0] exp_prev;
    exp_prev = '0;
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) begin
        checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== exp_prev) begin
          errors++; $display("FAIL b2b beat %0d: got %b/%h expected 1/%h", i - 1, c_out_valid, c_out_data, exp_prev);
        end
      end
      if (i < 24) begin
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat %0d: got %b expected 1", i, c_in_ready); end
        c_in_valid = 1'b1; c_in_data = $urandom;
        ref_lane(8, {32'h0, c_in_data}, 4, 1'b0, 1'b1, r);
        exp_prev = r[31:0];
      end else begin
        c_in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mode();
    logic [63:0] r;
    logic [31:0] e1, e2, e3;
    c_desc = 1'b1; c_load = 1'b1; c_in_valid = 1'b1; c_in_data = $urandom;
    ref_lane(8, {32'h0, c_in_data}, 4, 1'b0, 1'b1, r); e1 = r[31:0];
    @(negedge clk);
    c_load = 1'b0; c_desc = 1'b0;
    checks++; if (c_mode !== 1'b1) begin errors++; $display("FAIL mode_load: got %b expected 1", c_mode); end
    checks++; if (c_out_data !== e1) begin errors++; $display("FAIL mode_old_beat: got %h expected %h", c_out_data, e1); end
    c_in_data = $urandom;
    ref_lane(8, {32'h0, c_in_data}, 4, 1'b1, 1'b1, r); e2 = r[31:0];
    @(negedge clk);
    checks++; if (c_out_data !== e2) begin errors++; $display("FAIL mode_descramble: got %h expected %h", c_out_data, e2); end
    checks++; if (c_mode !== 1'b1) begin errors++; $display("FAIL mode_no_load: got %b expected 1", c_mode); end
    c_out_ready = 1'b0; c_in_data = $urandom; c_desc = 1'b0; c_load = 1'b1;
    #1;
    checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", c_in_ready); end
    @(negedge clk);
    c_load = 1'b0;
    checks++; if (c_mode !== 1'b0) begin errors++; $display("FAIL mode_reload: got %b expected 0", c_mode); end
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== e2) begin errors++; $display("FAIL mode_held_beat: got %b/%h expected 1/%h", c_out_valid, c_out_data, e2); end
    c_out_ready = 1'b1;
    ref_lane(8, {32'h0, c_in_data}, 4, 1'b0, 1'b1, r); e3 = r[31:0];
    @(negedge clk);
    c_in_valid = 1'b0;
    checks++; if (c_out_data !== e3) begin errors++; $display("FAIL mode_after_stall: got %h expected %h", c_out_data, e3); end
    @(negedge clk);
    c_reseed = 1'b1;
    seed_lane(8);
    @(negedge clk);
    c_reseed = 1'b0;
    checks++; if (c_out_valid !== 1'b0 || c_out_data !== e3) begin errors++; $display("FAIL reseed_idle_outreg: got %b/%h expected 0/%h", c_out_valid, c_out_data, e3); end
    c_in_valid = 1'b1; c_in_data = 32'h0;
    ref_lane(8, 64'h0, 4, 1'b0, 1'b1, r);
    @(negedge clk);
    c_in_valid = 1'b0;
    checks++; if (c_out_data !== 32'h0C000200) begin errors++; $display("FAIL reseed_idle_restart: got %h expected 0c000200", c_out_data); end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] r;
    @(negedge clk);
    c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_data = $urandom;
    ref_lane(8, {32'h0, c_in_data}, 4, 1'b0, 1'b1, r);
    @(negedge clk);
    c_in_valid = 1'b0;
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== r[31:0]) begin errors++; $display("FAIL midreset_held: got %b/%h expected 1/%h", c_out_valid, c_out_data, r[31:0]); end
    rstn_c = 1'b0;
    @(negedge clk);
    rstn_c = 1'b1;
    checks++; if (c_out_valid !== 1'b0 || c_out_data !== 32'h0) begin errors++; $display("FAIL midreset_drop: got %b/%h expected 0/0", c_out_valid, c_out_data); end
    seed_lane(8);
    c_out_ready = 1'b1; c_in_valid = 1'b1; c_in_data = $urandom;
    ref_lane(8, {32'h0, c_in_data}, 4, 1'b0, 1'b1, r);
    @(negedge clk);
    c_in_valid = 1'b0;
    checks++; if (c_out_data !== r[31:0]) begin errors++; $display("FAIL midreset_restart: got %h expected %h", c_out_data, r[31:0]); end
  endtask

  // Loopback A -> B with optional random downstream stalls, a reseed beat and a bypass window.
  task automatic test_stream(input string name, input int n, input bit stall,
                             input int rs_beat, input int off_lo, input int off_hi);
    logic [63:0] qa[$], qb[$];
    logic [63:0] ea, eb, exp, first_data, prev_a, prev_b;
    int sent, got, cyc;
    bit a_st, b_st;
    do_reset_ab();
    sent = 0; got = 0; cyc = 0; a_st = 1'b0; b_st = 1'b0;
    first_data = '0; prev_a = '0; prev_b = '0;
    while (got < n && cyc < 4 * n + 50) begin
      @(negedge clk);
      cyc++;
      if (a_st) begin
        checks++; if (a_out_data !== prev_a) begin errors++; $display("FAIL %s a_hold cyc %0d: got %h expected %h", name, cyc, a_out_data, prev_a); end
      end
      if (b_st) begin
        checks++; if (b_out_data !== prev_b) begin errors++; $display("FAIL %s b_hold cyc %0d: got %h expected %h", name, cyc, b_out_data, prev_b); end
      end
      a_in_valid = (sent < n);
      a_in_data = (sent == rs_beat) ? first_data : {$urandom, $urandom};
      if (sent == 0) first_data = a_in_data;
      a_reseed = (sent == rs_beat);
      a_en = !(sent >= off_lo && sent <= off_hi);
      b_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (a_in_valid && a_in_ready) begin
        model_a(a_in_data, a_en, a_reseed, ea);
        model_b(ea, eb);
        qa.push_back(ea); qb.push_back(eb);
        sent++;
      end else if (a_reseed) begin
        for (int l = 0; l < 4; l++) seed_lane(l);
      end
      if (a_out_valid && b_in_ready) begin
        exp = (qa.size() > 0) ? qa.pop_front() : 'x;
        checks++; if (a_out_data !== exp) begin errors++; $display("FAIL %s scramble: got %h expected %h", name, a_out_data, exp); end
      end
      if (b_out_valid && b_out_ready) begin
        exp = (qb.size() > 0) ? qb.pop_front() : 'x;
        checks++; if (b_out_data !== exp) begin errors++; $display("FAIL %s descramble beat %0d: got %h expected %h", name, got, b_out_data, exp); end
        got++;
      end
      a_st = a_out_valid && !b_in_ready; prev_a = a_out_data;
      b_st = b_out_valid && !b_out_ready; prev_b = b_out_data;
    end
    a_in_valid = 1'b0; a_reseed = 1'b0; a_en = 1'b1; b_out_ready = 1'b1;
    checks++; if (got != n) begin errors++; $display("FAIL %s beat_count: got %0d expected %0d", name, got, n); end
    if (!stall) begin
      checks++; if (cyc != n + 2) begin errors++; $display("FAIL %s throughput: got %0d cycles expected %0d", name, cyc, n + 2); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; rstn_c = 1'b1;
    a_en = 1'b1; a_desc = 1'b0; a_load = 1'b0; a_reseed = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    b_en = 1'b1; b_desc = 1'b1; b_load = 1'b0; b_reseed = 1'b0; b_out_ready = 1'b1;
    c_en = 1'b1; c_desc = 1'b0; c_load = 1'b0; c_reseed = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    test_reset();
    test_vector();
    test_back_to_back();
    test_mode();
    test_reset_midstream();
    test_stream("no_stall", 300, 1'b0, -1, -1, -1);
    test_stream("stall", 10000, 1'b1, -1, -1, -1);
    test_stream("reseed", 200, 1'b1, 100, -1, -1);
    test_stream("enable", 30, 1'b0, -1, 5, 9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
